// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every signal the fetch stage exchanges with its neighbours except
// clock and reset.
//   redirect, redirect_pc  : branch redirect pulse and its new PC
//   mem_re, mem_raddr      : instruction memory read request and address
//   mem_rvalid, mem_rdata  : in-order memory response
//   q_push, q_data         : push into the downstream instruction FIFO
//   q_pop_done             : consumer popped one FIFO entry (returns a credit)
// The master modport is the fetch unit; the slave modport is everything
// around it (memory, FIFO, branch logic).
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        q_push;
  logic [15:0] q_data;
  logic        q_pop_done;

  modport master (
    input  redirect, redirect_pc, mem_rvalid, mem_rdata, q_pop_done,
    output mem_re, mem_raddr, q_push, q_data
  );

  modport slave (
    output redirect, redirect_pc, mem_rvalid, mem_rdata, q_pop_done,
    input  mem_re, mem_raddr, q_push, q_data
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding a 16-bit instruction FIFO. Walks a 16-bit
// PC, issues in-order reads to instruction memory, and pushes each returned
// word into the FIFO. Credit-based flow control guarantees a push never meets
// a full FIFO. A redirect restarts fetch at a new PC and drops every response
// that was still in flight.
// Ports:
//   clk    : clock, all state changes on posedge
//   reset  : synchronous active-high reset
//   bus    : fetch_unit_if.master (redirect, memory and FIFO signals)
// Parameters:
//   DEPTH_LOG2 : log2 of FIFO capacity; credits start at 1<<DEPTH_LOG2
//   MAX_OUT    : maximum outstanding memory reads (1..15)
//   RESET_PC   : PC value after reset
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH_LOG2 = 5,
  parameter int          MAX_OUT    = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CREDITS_INIT = CW'(1) << DEPTH_LOG2;

  logic [15:0]   r_pc;
  logic [CW-1:0] r_credits;
  logic [3:0]    r_outstanding;
  logic [3:0]    r_discard;

  logic w_iss;
  logic w_rvalid;
  logic w_stale;
  logic w_push;
  logic w_staleReturn;

  // Request/response qualification. A response with nothing outstanding is
  // a protocol error and is dropped entirely, so w_rvalid is the only
  // response signal the counters ever look at. A response is stale when a
  // redirect lands in the same cycle or earlier redirects still have
  // responses to drain; stale responses hand their reserved credit back.
  always_comb begin
    w_rvalid      = !reset && bus.mem_rvalid && (r_outstanding != 4'd0);
    w_stale       = bus.redirect || (r_discard != 4'd0);
    w_iss         = !reset && !bus.redirect &&
                    (r_outstanding < 4'(MAX_OUT)) && (r_credits != '0);
    w_push        = w_rvalid && !w_stale;
    w_staleReturn = w_rvalid && w_stale;
  end

  assign bus.mem_re    = w_iss;
  assign bus.mem_raddr = r_pc;
  assign bus.q_push    = w_push;
  assign bus.q_data    = bus.mem_rdata;

  // State update. All counter terms apply together in one cycle. A credit is
  // reserved when a read issues; it is released either by the consumer's pop
  // (for words that made it into the FIFO) or directly when a stale response
  // is thrown away. On redirect every response still pending after this
  // cycle must be discarded, which is outstanding minus the one (if any)
  // arriving now.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_credits     <= CREDITS_INIT;
      r_outstanding <= 4'd0;
      r_discard     <= 4'd0;
    end else begin
      r_credits     <= r_credits - CW'(w_iss) + CW'(bus.q_pop_done)
                       + CW'(w_staleReturn);
      r_outstanding <= r_outstanding + 4'(w_iss) - 4'(w_rvalid);

      if (bus.redirect) begin
        r_pc      <= bus.redirect_pc;
        r_discard <= r_outstanding - 4'(w_rvalid);
      end else begin
        if (w_iss) begin
          r_pc <= r_pc + 16'd1;
        end
        if (w_staleReturn) begin
          r_discard <= r_discard - 4'd1;
        end
      end
    end
  end

endmodule
